// File: rtl/ctrl_pkg.sv
// Shared opcode and state definitions for the sequential rotate/logic unit.
package ctrl_pkg;

    localparam int OP_NOT = 0;
    localparam int OP_ROR = 1;
    localparam int OP_NOP = 2;
    localparam int OP_ROL = 3;
    localparam int OP_AND = 4;
    localparam int OP_OR  = 5;
    localparam int OP_XOR = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational core: single-cycle ops plus one-position rotate step.
module alu_logic_unit
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int OPW   = 3
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] step
);

    logic [WIDTH-1:0] ror1;
    logic [WIDTH-1:0] rol1;

    assign ror1 = {x[0], x[WIDTH-1:1]};
    assign rol1 = {x[WIDTH-2:0], x[WIDTH-1]};
    assign step = (op == OPW'(OP_ROL)) ? rol1 : ror1;

    // Rotates only reach this path with a zero amount, so they pass x through.
    always_comb begin
        y = '0;
        case (op)
            OPW'(OP_NOT): y = ~x;
            OPW'(OP_ROR): y = x;
            OPW'(OP_ROL): y = x;
            OPW'(OP_AND): y = x & b;
            OPW'(OP_OR):  y = x | b;
            OPW'(OP_XOR): y = x ^ b;
            default:      y = '0;
        endcase
    end

endmodule

// File: rtl/seq_rotate_alu.sv
// Handshaked NOT/rotate/logic unit; rotates advance one bit position per cycle.
module seq_rotate_alu
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, next_state;
    logic [WIDTH-1:0] work;
    logic [CW-1:0]    cnt;
    logic [OPW-1:0]   op_reg;
    logic [CW-1:0]    n;
    logic             is_rot;
    logic             accept;
    logic             load_result;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] alu_x;
    logic [OPW-1:0]   alu_op;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] alu_step;

    assign in_ready  = (state == ST_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign n         = CW'(b % WIDTH'(WIDTH));
    assign is_rot    = (op == OPW'(OP_ROR)) || (op == OPW'(OP_ROL));

    // In IDLE the ALU sees the live command; while shifting it sees the latched work word.
    assign alu_x  = (state == ST_IDLE) ? a  : work;
    assign alu_op = (state == ST_IDLE) ? op : op_reg;

    alu_logic_unit #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
        .x    (alu_x),
        .b    (b),
        .op   (alu_op),
        .y    (alu_y),
        .step (alu_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state  = state;
        load_result = 1'b0;
        result_d    = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (is_rot && (n != '0)) begin
                        next_state = ST_SHIFT;
                    end else begin
                        load_result = 1'b1;
                        result_d    = alu_y;
                        next_state  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                if (cnt == CW'(1)) begin
                    load_result = 1'b1;
                    result_d    = alu_step;
                    next_state  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work   <= '0;
            cnt    <= '0;
            op_reg <= '0;
            result <= '0;
            flag   <= 1'b0;
        end else begin
            if (accept) begin
                work   <= a;
                cnt    <= n;
                op_reg <= op;
            end else if (state == ST_SHIFT) begin
                work <= alu_step;
                cnt  <= cnt - CW'(1);
            end
            if (load_result) begin
                result <= result_d;
                flag   <= |result_d;
            end
        end
    end

endmodule

// File: tb/tb_seq_rotate_alu.sv
// Directed checks of seq_rotate_alu at WIDTH=7 with hand-computed expectations.
module tb_seq_rotate_alu;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] a;
    logic [6:0] b;
    logic [2:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [6:0] result;
    logic       flag;
    logic       busy;

    int checks;
    int errors;
    int lat;

    seq_rotate_alu #(.WIDTH(7), .OPW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag      (flag),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command and returns the edge count (accept edge included) until out_valid.
    task automatic applyStimulus(input logic [2:0] o, input logic [6:0] av, input logic [6:0] bv,
                                 output int latency);
        @(negedge clk);
        op = o; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 7'h00; b = 7'h00; op = 3'd2;
        latency = 1;
        while (!out_valid && latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic releaseResult();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = 7'h00; b = 7'h00; op = 3'd0;

        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result",    32'(result),    32'd0);
        checkOutput("reset_flag",      32'(flag),      32'd0);
        checkOutput("reset_busy",      32'(busy),      32'd0);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(3'd0, 7'h55, 7'h00, lat);
        checkOutput("not55_latency",  32'(lat),      32'd1);
        checkOutput("not55_result",   32'(result),   32'h2A);
        checkOutput("not55_flag",     32'(flag),     32'd1);
        checkOutput("not55_in_ready", 32'(in_ready), 32'd0);
        checkOutput("not55_busy",     32'(busy),     32'd1);
        releaseResult();
        checkOutput("not55_back_idle", 32'(in_ready), 32'd1);

        applyStimulus(3'd1, 7'b0000001, 7'd3, lat);
        checkOutput("ror3_latency", 32'(lat),    32'd4);
        checkOutput("ror3_result",  32'(result), 32'h10);
        checkOutput("ror3_flag",    32'(flag),   32'd1);
        releaseResult();

        applyStimulus(3'd3, 7'b1000000, 7'd9, lat);
        checkOutput("rol9_latency", 32'(lat),    32'd3);
        checkOutput("rol9_result",  32'(result), 32'h02);
        releaseResult();

        applyStimulus(3'd0, 7'h7F, 7'h00, lat);
        checkOutput("not7f_result", 32'(result), 32'h00);
        checkOutput("not7f_flag",   32'(flag),   32'd0);
        releaseResult();

        applyStimulus(3'd2, 7'h5A, 7'h33, lat);
        checkOutput("nop_latency", 32'(lat),    32'd1);
        checkOutput("nop_result",  32'(result), 32'h00);
        checkOutput("nop_flag",    32'(flag),   32'd0);
        releaseResult();

        applyStimulus(3'd7, 7'h5A, 7'h33, lat);
        checkOutput("op7_result", 32'(result), 32'h00);
        releaseResult();

        applyStimulus(3'd4, 7'h6C, 7'h3A, lat);
        checkOutput("and_result", 32'(result), 32'h28);
        releaseResult();

        applyStimulus(3'd5, 7'h41, 7'h12, lat);
        checkOutput("or_result", 32'(result), 32'h53);
        releaseResult();

        applyStimulus(3'd1, 7'h2B, 7'd7, lat);
        checkOutput("ror7_latency", 32'(lat),    32'd1);
        checkOutput("ror7_result",  32'(result), 32'h2B);
        releaseResult();

        applyStimulus(3'd6, 7'h3C, 7'h3C, lat);
        checkOutput("xor_result", 32'(result), 32'h00);
        checkOutput("xor_flag",   32'(flag),   32'd0);
        releaseResult();

        // Backpressure: hold DONE for five cycles while upstream pokes in_valid.
        applyStimulus(3'd3, 7'b0000001, 7'd1, lat);
        checkOutput("bp_latency", 32'(lat),    32'd2);
        checkOutput("bp_result",  32'(result), 32'h02);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0); op = 3'd0; a = 7'h00; b = 7'h00;
            @(posedge clk);
            #1;
            checkOutput($sformatf("bp_result_%0d", i),    32'(result),    32'h02);
            checkOutput($sformatf("bp_flag_%0d", i),      32'(flag),      32'd1);
            checkOutput($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_in_ready_%0d", i),  32'(in_ready),  32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        releaseResult();
        checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_busy",      32'(busy),      32'd0);
        checkOutput("bp_release_in_ready",  32'(in_ready),  32'd1);
        checkOutput("bp_release_hold",      32'(result),    32'h02);

        // Reset in the middle of a 5-step rotate.
        @(negedge clk);
        op = 3'd1; a = 7'b0000001; b = 7'd5; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("mid_shift_busy", 32'(busy), 32'd1);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_busy",      32'(busy),      32'd0);
        checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_mid_result",    32'(result),    32'd0);
        checkOutput("rst_mid_flag",      32'(flag),      32'd0);
        checkOutput("rst_mid_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("post_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("post_rst_busy",      32'(busy),      32'd0);

        applyStimulus(3'd1, 7'b0000001, 7'd5, lat);
        checkOutput("post_rst_ror5_latency", 32'(lat),    32'd6);
        checkOutput("post_rst_ror5_result",  32'(result), 32'h04);
        releaseResult();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
